// File: rtl/ex_muldiv_unit_pkg.sv
// Shared definitions for the multiply/divide engine: op codes, reset level, FSM states.
package ex_muldiv_unit_pkg;

  localparam logic RESET_ENABLE = 1'b0;

  // Bit 0 set marks the unsigned form; codes 6/7 are the divides.
  localparam logic [2:0] MULDIV_OP_MULT  = 3'd0;
  localparam logic [2:0] MULDIV_OP_MULTU = 3'd1;
  localparam logic [2:0] MULDIV_OP_MADD  = 3'd2;
  localparam logic [2:0] MULDIV_OP_MADDU = 3'd3;
  localparam logic [2:0] MULDIV_OP_MSUB  = 3'd4;
  localparam logic [2:0] MULDIV_OP_MSUBU = 3'd5;
  localparam logic [2:0] MULDIV_OP_DIV   = 3'd6;
  localparam logic [2:0] MULDIV_OP_DIVU  = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } muldiv_state_t;

  function automatic logic op_is_div(input logic [2:0] op);
    return op[2:1] == 2'b11;
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return !op[0];
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_divider_core.sv
// Unsigned restoring divider, one quotient bit per cycle, DATA_WIDTH cycles per divide.
module muldiv_divider_core
  import ex_muldiv_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] dividend,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] quotient,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  ready
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic [W-1:0]   dsr;
  logic [CW-1:0]  count;
  logic [2*W-1:0] first_step;
  logic [2*W-1:0] next_step;

  // Returns {remainder, quotient} after shifting in one dividend bit.
  function automatic logic [2*W-1:0] div_step(input logic [W-1:0] rem,
                                              input logic [W-1:0] quo,
                                              input logic [W-1:0] d);
    logic [W:0] shifted;
    logic [W:0] trial;
    shifted = {rem, quo[W-1]};
    trial   = shifted - {1'b0, d};
    if (!trial[W]) return {trial[W-1:0], quo[W-2:0], 1'b1};
    return {shifted[W-1:0], quo[W-2:0], 1'b0};
  endfunction

  always_comb begin
    first_step = div_step('0, dividend, divisor);
    next_step  = div_step(remainder, quotient, dsr);
  end

  assign ready = (count == '0);

  // The load edge already performs the first iteration, so DATA_WIDTH edges in total.
  always_ff @(posedge clock or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      quotient  <= '0;
      remainder <= '0;
      dsr       <= '0;
      count     <= '0;
    end else if (start) begin
      {remainder, quotient} <= first_step;
      dsr                   <= divisor;
      count                 <= CW'(DATA_WIDTH - 1);
    end else if (abort) begin
      count <= '0;
    end else if (count != '0) begin
      {remainder, quotient} <= next_step;
      count                 <= count - CW'(1);
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Multi-cycle multiply/divide engine producing new HI/LO values beside the execute stage.
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MUL_STAGES = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [2:0]            operator,
  input  logic [DATA_WIDTH-1:0] operand_a,
  input  logic [DATA_WIDTH-1:0] operand_b,
  input  logic [DATA_WIDTH-1:0] hi_in,
  input  logic [DATA_WIDTH-1:0] lo_in,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out,
  output logic                  div_by_zero
);

  localparam int W = DATA_WIDTH;

  muldiv_state_t  state;
  logic [7:0]     mul_cnt;
  logic           neg_q, neg_r;
  logic           start_ok, is_div, sgn, b_zero;
  logic           div_start, div_abort, div_ready;
  logic [W-1:0]   mag_a, mag_b, quotient, remainder, q_fix, r_fix;
  logic [2*W-1:0] ext_a, ext_b, product, mul_full, mul_res;

  always_comb begin
    is_div    = op_is_div(operator);
    sgn       = op_is_signed(operator);
    b_zero    = (operand_b == '0);
    start_ok  = start && !flush && (state == S_IDLE);
    div_start = start_ok && is_div && !b_zero;
    div_abort = flush && (state == S_DIV);
    mag_a     = (sgn && operand_a[W-1]) ? -operand_a : operand_a;
    mag_b     = (sgn && operand_b[W-1]) ? -operand_b : operand_b;
    ext_a     = sgn ? {{W{operand_a[W-1]}}, operand_a} : {{W{1'b0}}, operand_a};
    ext_b     = sgn ? {{W{operand_b[W-1]}}, operand_b} : {{W{1'b0}}, operand_b};
    product   = ext_a * ext_b;
    case (operator)
      MULDIV_OP_MADD, MULDIV_OP_MADDU: mul_full = {hi_in, lo_in} + product;
      MULDIV_OP_MSUB, MULDIV_OP_MSUBU: mul_full = {hi_in, lo_in} - product;
      default:                         mul_full = product;
    endcase
    q_fix = neg_q ? -quotient : quotient;
    r_fix = neg_r ? -remainder : remainder;
  end

  // Product is formed from the live inputs in the start cycle; the trailing registers
  // give synthesis room to retime the multiplier. The output register is the last stage.
  generate
    if (MUL_STAGES == 1) begin : g_mul_comb
      assign mul_res = mul_full;
    end else begin : g_mul_pipe
      logic [2*W-1:0] pipe [MUL_STAGES-1];
      always_ff @(posedge clock or negedge reset) begin
        if (reset == RESET_ENABLE) begin
          for (int unsigned i = 0; i < MUL_STAGES - 1; i++) pipe[i] <= '0;
        end else begin
          pipe[0] <= mul_full;
          for (int unsigned i = 1; i < MUL_STAGES - 1; i++) pipe[i] <= pipe[i-1];
        end
      end
      assign mul_res = pipe[MUL_STAGES-2];
    end
  endgenerate

  muldiv_divider_core #(.DATA_WIDTH(DATA_WIDTH)) u_divider (
    .clock     (clock),
    .reset     (reset),
    .start     (div_start),
    .abort     (div_abort),
    .dividend  (mag_a),
    .divisor   (mag_b),
    .quotient  (quotient),
    .remainder (remainder),
    .ready     (div_ready)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      state       <= S_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi_out      <= '0;
      lo_out      <= '0;
      mul_cnt     <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      case (state)
        S_IDLE: if (start_ok) begin
          busy <= 1'b1;
          if (is_div && b_zero) begin
            state       <= S_DONE;
            done        <= 1'b1;
            div_by_zero <= 1'b1;
            hi_out      <= operand_a;
            lo_out      <= '1;
          end else if (is_div) begin
            state <= S_DIV;
            neg_q <= sgn && (operand_a[W-1] ^ operand_b[W-1]);
            neg_r <= sgn && operand_a[W-1];
          end else if (MUL_STAGES == 1) begin
            state            <= S_DONE;
            done             <= 1'b1;
            {hi_out, lo_out} <= mul_res;
          end else begin
            state   <= S_MUL;
            mul_cnt <= 8'(MUL_STAGES - 2);
          end
        end
        S_MUL: if (flush) begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end else if (mul_cnt == '0) begin
          state            <= S_DONE;
          done             <= 1'b1;
          {hi_out, lo_out} <= mul_res;
        end else begin
          mul_cnt <= mul_cnt - 8'd1;
        end
        S_DIV: if (flush) begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end else if (div_ready) begin
          state <= S_FIX;
        end
        S_FIX: if (flush) begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end else begin
          state  <= S_DONE;
          done   <= 1'b1;
          hi_out <= r_fix;
          lo_out <= q_fix;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Self-checking bench for ex_muldiv_unit: directed vectors, random ops against a model, corner sequences.
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  localparam int DW = 32;
  localparam int MS = 2;

  logic          clock, reset, start, flush;
  logic [2:0]    operator;
  logic [DW-1:0] operand_a, operand_b, hi_in, lo_in;
  logic          busy, done, div_by_zero;
  logic [DW-1:0] hi_out, lo_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] hold_h, hold_l;

  ex_muldiv_unit #(.DATA_WIDTH(DW), .MUL_STAGES(MS)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .operator    (operator),
    .operand_a   (operand_a),
    .operand_b   (operand_b),
    .hi_in       (hi_in),
    .lo_in       (lo_in),
    .flush       (flush),
    .busy        (busy),
    .done        (done),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .div_by_zero (div_by_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]    op;
    logic [DW-1:0] a, b, h, l, eh, el;
    logic          edbz;
    int            lat;
  } vec_t;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Reference: results straight from integer arithmetic on the operand values.
  function automatic logic [64:0] ref_model(input logic [2:0] op, input logic [31:0] a, b, h, l);
    longint     sa, sb;
    logic [63:0] prod, acc;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    acc = {h, l};
    if (op == MULDIV_OP_DIV || op == MULDIV_OP_DIVU) begin
      if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
      if (op == MULDIV_OP_DIV) return {1'b0, 32'(sa % sb), 32'(sa / sb)};
      return {1'b0, a % b, a / b};
    end
    if (op == MULDIV_OP_MULT || op == MULDIV_OP_MADD || op == MULDIV_OP_MSUB) prod = 64'(sa * sb);
    else prod = {32'd0, a} * {32'd0, b};
    if (op == MULDIV_OP_MADD || op == MULDIV_OP_MADDU) return {1'b0, acc + prod};
    if (op == MULDIV_OP_MSUB || op == MULDIV_OP_MSUBU) return {1'b0, acc - prod};
    return {1'b0, prod};
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input logic [31:0] b);
    if (op == MULDIV_OP_DIV || op == MULDIV_OP_DIVU) return (b == 32'd0) ? 1 : DW + 2;
    return MS;
  endfunction

  task automatic drive_garbage();
    start     = 1'($urandom_range(0, 1));
    operator  = 3'($urandom_range(0, 7));
    operand_a = $urandom;
    operand_b = $urandom;
    hi_in     = $urandom;
    lo_in     = $urandom;
  endtask

  // Called at #1 after a rising edge; returns one cycle after done with start low.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, b, h, l,
                        output int lat, output logic busy_ok,
                        output logic [31:0] rh, rl, output logic rdbz);
    start = 1'b1; operator = op; operand_a = a; operand_b = b; hi_in = h; lo_in = l;
    busy_ok = 1'b1;
    @(posedge clock); #1;
    lat = 1;
    while (!done && lat < 100) begin
      if (!busy) busy_ok = 1'b0;
      drive_garbage();
      @(posedge clock); #1;
      lat++;
    end
    if (!busy) busy_ok = 1'b0;
    rh = hi_out; rl = lo_out; rdbz = div_by_zero;
    drive_garbage();
    @(posedge clock); #1;
    if (done || busy || div_by_zero) busy_ok = 1'b0;
    start = 1'b0;
  endtask

  task automatic exec_and_check(input string tag, input logic [2:0] op, input logic [31:0] a, b, h, l,
                                input logic [31:0] eh, el, input logic edbz, input int elat);
    int lat; logic bok; logic [31:0] rh, rl; logic rdbz;
    run_op(op, a, b, h, l, lat, bok, rh, rl, rdbz);
    check({tag, "_result"}, {rdbz, rh, rl}, {edbz, eh, el});
    check({tag, "_latency"}, lat, elat);
    check({tag, "_busy"}, bok, 1'b1);
    hold_h = eh; hold_l = el;
  endtask

  vec_t vecs[13];

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b, h, l;
    logic [64:0] exp;
    logic        seen;

    vecs[0]  = '{MULDIV_OP_MULT,  32'hFFFF_FFFD, 32'd7, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, MS};
    vecs[1]  = '{MULDIV_OP_MADDU, 32'd1, 32'd1, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, MS};
    vecs[2]  = '{MULDIV_OP_DIV,   32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 34};
    vecs[3]  = '{MULDIV_OP_DIVU,  32'd7, 32'd2, 32'd0, 32'd0, 32'd1, 32'd3, 1'b0, 34};
    vecs[4]  = '{MULDIV_OP_DIV,   32'd5, 32'd0, 32'd0, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1};
    vecs[5]  = '{MULDIV_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0, 32'h8000_0000, 1'b0, 34};
    vecs[6]  = '{MULDIV_OP_MSUB,  32'd2, 32'd3, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0, MS};
    vecs[7]  = '{MULDIV_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0, 32'hFFFF_FFFE, 32'd1, 1'b0, MS};
    vecs[8]  = '{MULDIV_OP_DIVU,  32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 1'b0, 34};
    vecs[9]  = '{MULDIV_OP_DIV,   32'd7, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'd1, 32'hFFFF_FFFD, 1'b0, 34};
    vecs[10] = '{MULDIV_OP_MADD,  32'd1, 32'd1, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, MS};
    vecs[11] = '{MULDIV_OP_DIVU,  32'd5, 32'd0, 32'd0, 32'd0, 32'd5, 32'hFFFF_FFFF, 1'b1, 1};
    vecs[12] = '{MULDIV_OP_MSUBU, 32'd1, 32'd1, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, MS};

    reset = 1'b0; start = 1'b0; flush = 1'b0; operator = '0;
    operand_a = '0; operand_b = '0; hi_in = '0; lo_in = '0;
    repeat (3) @(posedge clock);
    #1;
    check("reset_state", {busy, done, div_by_zero, hi_out, lo_out}, '0);
    reset = 1'b1;
    @(posedge clock); #1;

    for (int i = 0; i < 13; i++)
      exec_and_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].h, vecs[i].l,
                     vecs[i].eh, vecs[i].el, vecs[i].edbz, vecs[i].lat);

    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom; h = $urandom; l = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: b = 32'($urandom_range(1, 9));
        2: begin a = 32'h8000_0000; b = '1; end
        default: ;
      endcase
      exp = ref_model(op, a, b, h, l);
      exec_and_check($sformatf("rnd%0d", i), op, a, b, h, l, exp[63:32], exp[31:0], exp[64],
                     ref_latency(op, b));
    end

    // Idle: results hold, no stray pulses.
    repeat (3) @(posedge clock);
    #1;
    check("idle_hold", {done, busy, div_by_zero, hi_out, lo_out}, {3'b000, hold_h, hold_l});

    // Flush a DIVU at cycle 10.
    start = 1'b1; operator = MULDIV_OP_DIVU; operand_a = 32'd100; operand_b = 32'd3;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    check("flush_div_idle", {busy, done}, 2'b00);
    check("flush_div_hold", {hi_out, lo_out}, {hold_h, hold_l});
    seen = 1'b0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) seen = 1'b1;
    end
    check("flush_div_no_done", seen, 1'b0);
    exec_and_check("after_flush_mult", MULDIV_OP_MULT, 32'd6, 32'hFFFF_FFF9, 32'd0, 32'd0,
                   32'hFFFF_FFFF, 32'hFFFF_FFD6, 1'b0, MS);

    // Flush a multiply in its first busy cycle.
    start = 1'b1; operator = MULDIV_OP_MULTU; operand_a = 32'd3; operand_b = 32'd3;
    @(posedge clock); #1;
    start = 1'b0; flush = 1'b1;
    @(posedge clock); #1;
    flush = 1'b0;
    seen = done;
    repeat (5) begin
      @(posedge clock); #1;
      if (done || busy) seen = 1'b1;
    end
    check("flush_mul_quiet", {seen, busy, hi_out, lo_out}, {2'b00, hold_h, hold_l});

    // start together with flush is dropped.
    start = 1'b1; flush = 1'b1; operator = MULDIV_OP_DIV; operand_a = 32'd9; operand_b = 32'd0;
    @(posedge clock); #1;
    start = 1'b0; flush = 1'b0;
    check("start_flush_dropped", {busy, done, div_by_zero, hi_out, lo_out}, {3'b000, hold_h, hold_l});

    // Reset in the middle of a divide.
    start = 1'b1; operator = MULDIV_OP_DIV; operand_a = 32'd1000; operand_b = 32'd7;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (15) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    check("reset_mid_div", {busy, done, div_by_zero, hi_out, lo_out}, '0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    exec_and_check("after_reset_mult", MULDIV_OP_MULT, 32'd6, 32'd7, 32'd0, 32'd0,
                   32'd0, 32'd42, 1'b0, MS);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
